operand_stage: RTL and testbench

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/operand_stage_pkg.sv | 13 +
 rtl/operand_fwd_mux.sv | 46 ++++
 rtl/operand_stage.sv | 129 ++++++++++++
 tb/tb_operand_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand stage: the encodings of the ALU operand source types.
package operand_stage_pkg;

    typedef enum logic [1:0] {
        OP_TYPE_NONE = 2'd0,
        OP_TYPE_REG  = 2'd1,
        OP_TYPE_IMM  = 2'd2,
        OP_TYPE_PC   = 2'd3
    } op_type_e;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational operand select for one source operand. It picks the forwarded register value,
// or the immediate, the PC or zero, according to the operand type.
module operand_fwd_mux
    import operand_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NFWD  = 2,
    parameter int RADDR = 5
) (
    input  op_type_e               op_type,
    input  logic [RADDR-1:0]       rs_addr,
    input  logic [XLEN-1:0]        regdata,
    input  logic [XLEN-1:0]        imm,
    input  logic [XLEN-1:0]        pc,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_busy,
    input  logic [NFWD*RADDR-1:0]  fwd_addr,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]        reg_value,
    output logic [XLEN-1:0]        operand
);

    // Walk from oldest to youngest so the lowest-index ready match is written last.
    always_comb begin
        reg_value = regdata;
        if (rs_addr != '0) begin
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && !fwd_busy[i] && (fwd_addr[i*RADDR +: RADDR] == rs_addr)) begin
                    reg_value = fwd_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        operand = '0;
        case (op_type)
            OP_TYPE_NONE: operand = '0;
            OP_TYPE_REG:  operand = reg_value;
            OP_TYPE_IMM:  operand = imm;
            OP_TYPE_PC:   operand = pc;
            default:      operand = '0;
        endcase
    end

endmodule

// File: rtl/operand_stage.sv
// Operand stage: selects and forwards the two ALU operands and the store data, stalls on
// pending producer results and registers the result behind a valid/ready output stage.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NFWD  = 2,
    parameter int RADDR = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             aluop1_type,
    input  logic [1:0]             aluop2_type,
    input  logic [RADDR-1:0]       rs1_addr,
    input  logic [RADDR-1:0]       rs2_addr,
    input  logic [XLEN-1:0]        regdata1,
    input  logic [XLEN-1:0]        regdata2,
    input  logic [XLEN-1:0]        imm,
    input  logic [XLEN-1:0]        pc,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_busy,
    input  logic [NFWD*RADDR-1:0]  fwd_addr,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        oprl,
    output logic [XLEN-1:0]        oprr,
    output logic [XLEN-1:0]        store_data,
    output logic [31:0]            stall_cnt
);

    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            rs1_hazard;
    logic            rs2_hazard;
    logic            hazard;
    logic            capture;

    operand_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD), .RADDR(RADDR)) u_mux1 (
        .op_type   (op_type_e'(aluop1_type)),
        .rs_addr   (rs1_addr),
        .regdata   (regdata1),
        .imm       (imm),
        .pc        (pc),
        .fwd_valid (fwd_valid),
        .fwd_busy  (fwd_busy),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .reg_value (rs1_value),
        .operand   (op1)
    );

    operand_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD), .RADDR(RADDR)) u_mux2 (
        .op_type   (op_type_e'(aluop2_type)),
        .rs_addr   (rs2_addr),
        .regdata   (regdata2),
        .imm       (imm),
        .pc        (pc),
        .fwd_valid (fwd_valid),
        .fwd_busy  (fwd_busy),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .reg_value (rs2_value),
        .operand   (op2)
    );

    // The youngest valid writer of a register decides: if it is still busy, the value is not ready.
    function automatic logic busy_hit(input logic [RADDR-1:0] rs,
                                      input logic [NFWD-1:0] vld,
                                      input logic [NFWD-1:0] bsy,
                                      input logic [NFWD*RADDR-1:0] addr);
        logic found;
        logic hit;
        found = 1'b0;
        hit   = 1'b0;
        if (rs != '0) begin
            for (int i = 0; i < NFWD; i++) begin
                if (!found && vld[i] && (addr[i*RADDR +: RADDR] == rs)) begin
                    found = 1'b1;
                    hit   = bsy[i];
                end
            end
        end
        return hit;
    endfunction

    assign rs1_hazard = busy_hit(rs1_addr, fwd_valid, fwd_busy, fwd_addr);
    assign rs2_hazard = busy_hit(rs2_addr, fwd_valid, fwd_busy, fwd_addr);

    // rs2 always feeds store_data, so its readiness matters even for a non-register operand 2.
    assign hazard = ((op_type_e'(aluop1_type) == OP_TYPE_REG) && rs1_hazard) || rs2_hazard;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high; valid
    // never waits for ready, ready never looks at valid, and held data stays stable while valid && !ready.
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            oprl       <= '0;
            oprr       <= '0;
            store_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            oprl       <= op1;
            oprr       <= op2;
            store_data <= rs2_value;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && !flush && (stall_cnt != STALL_CNT_MAX)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios followed by random traffic, with a
// scoreboard of expected output operations.
module tb_operand_stage;
    import operand_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int NFWD  = 2;
    localparam int RADDR = 5;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            aluop1_type;
    logic [1:0]            aluop2_type;
    logic [RADDR-1:0]      rs1_addr;
    logic [RADDR-1:0]      rs2_addr;
    logic [XLEN-1:0]       regdata1;
    logic [XLEN-1:0]       regdata2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [NFWD-1:0]       fwd_valid;
    logic [NFWD-1:0]       fwd_busy;
    logic [NFWD*RADDR-1:0] fwd_addr;
    logic [NFWD*XLEN-1:0]  fwd_data;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       oprl;
    logic [XLEN-1:0]       oprr;
    logic [XLEN-1:0]       store_data;
    logic [31:0]           stall_cnt;

    always #5 clk = ~clk;

    operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .RADDR(RADDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluop1_type (aluop1_type),
        .aluop2_type (aluop2_type),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .regdata1    (regdata1),
        .regdata2    (regdata2),
        .imm         (imm),
        .pc          (pc),
        .fwd_valid   (fwd_valid),
        .fwd_busy    (fwd_busy),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .oprl        (oprl),
        .oprr        (oprr),
        .store_data  (store_data),
        .stall_cnt   (stall_cnt)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] m_fwd(input logic [RADDR-1:0] rs, input logic [XLEN-1:0] rd);
        if (rs == '0) return rd;
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_valid[i] && !fwd_busy[i] && fwd_addr[i*RADDR +: RADDR] == rs)
                return fwd_data[i*XLEN +: XLEN];
        end
        return rd;
    endfunction

    function automatic logic m_busy(input logic [RADDR-1:0] rs);
        if (rs == '0) return 1'b0;
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_valid[i] && fwd_addr[i*RADDR +: RADDR] == rs) return fwd_busy[i];
        end
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] m_sel(input logic [1:0] t, input logic [RADDR-1:0] rs,
                                              input logic [XLEN-1:0] rd);
        case (t)
            OP_TYPE_REG: return m_fwd(rs, rd);
            OP_TYPE_IMM: return imm;
            OP_TYPE_PC:  return pc;
            default:     return '0;
        endcase
    endfunction

    function automatic logic m_hazard();
        return ((aluop1_type == OP_TYPE_REG) && m_busy(rs1_addr)) || m_busy(rs2_addr);
    endfunction

    // ---------------- scoreboard ----------------
    logic [3*XLEN-1:0] exp_q[$];
    logic [31:0]       exp_stall = 32'd0;

    // Inputs change 1 time unit after posedge; this samples the settled state ahead of the next edge.
    always @(negedge clk) begin
        logic              exp_valid;
        logic              hz;
        logic              rdy;
        logic [3*XLEN-1:0] e;
        if (rst === 1'b0) begin
            exp_valid = (exp_q.size() != 0);
            hz        = m_hazard();
            rdy       = !hz && (!exp_valid || out_ready);
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("stall_cnt", stall_cnt, exp_stall);
            if (exp_valid) begin
                e = exp_q[0];
                check("oprl", oprl, e[3*XLEN-1 -: XLEN]);
                check("oprr", oprr, e[2*XLEN-1 -: XLEN]);
                check("store_data", store_data, e[XLEN-1:0]);
                if (out_ready || flush) void'(exp_q.pop_front());
            end
            if (!flush && in_valid && rdy)
                exp_q.push_back({m_sel(aluop1_type, rs1_addr, regdata1),
                                 m_sel(aluop2_type, rs2_addr, regdata2),
                                 m_fwd(rs2_addr, regdata2)});
            if (in_valid && hz && !flush && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int p, input logic v, input logic b,
                           input logic [RADDR-1:0] a, input logic [XLEN-1:0] d);
        fwd_valid[p]               = v;
        fwd_busy[p]                = b;
        fwd_addr[p*RADDR +: RADDR] = a;
        fwd_data[p*XLEN +: XLEN]   = d;
    endtask

    task automatic set_op(input logic [1:0] t1, input logic [1:0] t2,
                          input logic [RADDR-1:0] r1, input logic [RADDR-1:0] r2,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                          input logic [XLEN-1:0] im, input logic [XLEN-1:0] p);
        aluop1_type = t1;
        aluop2_type = t2;
        rs1_addr    = r1;
        rs2_addr    = r2;
        regdata1    = d1;
        regdata2    = d2;
        imm         = im;
        pc          = p;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        fwd_valid = '0;
        fwd_busy  = '0;
        fwd_addr  = '0;
        fwd_data  = '0;
        set_op(OP_TYPE_NONE, OP_TYPE_NONE, '0, '0, '0, '0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_oprl", oprl, 32'd0);
        check("reset_oprr", oprr, 32'd0);
        check("reset_store", store_data, 32'd0);
        check("reset_stall", stall_cnt, 32'd0);
        step();
        rst = 1'b0;

        // register + immediate, no forwarding
        set_op(OP_TYPE_REG, OP_TYPE_IMM, 5'd5, 5'd0, 32'h10, 32'h0, 32'h4, 32'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_oprl", oprl, 32'h10);
        check("t1_oprr", oprr, 32'h4);
        step();

        // youngest port wins; x0 never forwards
        set_fwd(1, 1'b1, 1'b0, 5'd3, 32'hAA);
        set_fwd(0, 1'b1, 1'b0, 5'd3, 32'hBB);
        set_op(OP_TYPE_REG, OP_TYPE_NONE, 5'd3, 5'd0, 32'h11, 32'h0, 32'h0, 32'h0);
        in_valid = 1'b1;
        step();
        check("t2_fwd_prio", oprl, 32'hBB);
        rs1_addr = 5'd0;
        regdata1 = 32'h123;
        step();
        in_valid = 1'b0;
        check("t2_x0", oprl, 32'h123);
        idle();
        step();

        // busy producer stalls rs2 for three cycles, then forwards
        set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h0);
        set_op(OP_TYPE_NONE, OP_TYPE_REG, 5'd0, 5'd7, 32'h0, 32'h99, 32'h0, 32'h0);
        in_valid = 1'b1;
        #1 check("t3_ready_low", 32'(in_ready), 32'd0);
        step();
        step();
        step();
        check("t3_stall3", stall_cnt, 32'd3);
        check("t3_still_low", 32'(in_ready), 32'd0);
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h55);
        step();
        in_valid = 1'b0;
        check("t3_oprr", oprr, 32'h55);
        check("t3_store", store_data, 32'h55);
        check("t3_stall_hold", stall_cnt, 32'd3);

        // shadowing: busy older behind ready younger is fine; the reverse stalls
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h66);
        set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h0);
        in_valid = 1'b1;
        #1 check("t4_shadow_ok", 32'(in_ready), 32'd1);
        step();
        check("t4_shadow_val", oprr, 32'h66);
        set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h0);
        set_fwd(1, 1'b1, 1'b0, 5'd7, 32'h77);
        #1 check("t4_shadow_haz", 32'(in_ready), 32'd0);
        step();
        idle();
        step();

        // non-register operand 1 ignores a busy match
        set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h0);
        set_op(OP_TYPE_IMM, OP_TYPE_PC, 5'd7, 5'd0, 32'h0, 32'h0, 32'h44, 32'h80);
        in_valid = 1'b1;
        #1 check("t5_imm_nohaz", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t5_imm", oprl, 32'h44);
        check("t5_pc", oprr, 32'h80);
        idle();
        step();

        // backpressure holds outputs; drain plus capture has no bubble
        out_ready = 1'b0;
        set_op(OP_TYPE_IMM, OP_TYPE_NONE, 5'd0, 5'd0, 32'h0, 32'h0, 32'hA1, 32'h0);
        in_valid = 1'b1;
        step();
        imm = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            check("t6_hold_valid", 32'(out_valid), 32'd1);
            check("t6_hold_oprl", oprl, 32'hA1);
            check("t6_hold_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t6_b2b_valid", 32'(out_valid), 32'd1);
        check("t6_b2b_oprl", oprl, 32'hB2);
        step();
        check("t6_drained", 32'(out_valid), 32'd0);

        // flush drops held and incoming operations
        out_ready = 1'b0;
        imm = 32'hC3;
        in_valid = 1'b1;
        step();
        imm = 32'hD4;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t7_flushed", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        check("t7_no_capture", 32'(out_valid), 32'd0);

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        imm = 32'hE5;
        in_valid = 1'b1;
        step();
        set_fwd(0, 1'b1, 1'b1, 5'd9, 32'h0);
        set_op(OP_TYPE_REG, OP_TYPE_NONE, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        check("t8_stall_pre", stall_cnt, exp_stall);
        #2 rst = 1'b1;
        exp_q.delete();
        exp_stall = 32'd0;
        #1;
        check("t8_rst_valid", 32'(out_valid), 32'd0);
        check("t8_rst_stall", stall_cnt, 32'd0);
        check("t8_rst_oprl", oprl, 32'd0);
        step();
        idle();
        set_op(OP_TYPE_IMM, OP_TYPE_NONE, 5'd0, 5'd0, 32'h0, 32'h0, 32'hF6, 32'h0);
        in_valid = 1'b1;
        rst = 1'b0;
        step();
        in_valid = 1'b0;
        check("t8_first_cap", 32'(out_valid), 32'd1);
        check("t8_first_oprl", oprl, 32'hF6);
        idle();
        step();

        // random traffic against the scoreboard
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NFWD; p++)
                set_fwd(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                        RADDR'($urandom_range(0, 7)), $urandom);
            set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   RADDR'($urandom_range(0, 7)), RADDR'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
